// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter granting one of N_REQ byte sources access to a single UART transmitter.
// Latency: ack/grant one edge after the request is seen in IDLE, tx_start one edge after that.
// Backpressure: requests are sampled only in IDLE; holding i_tx_busy high stalls the arbiter in WAIT_DONE.
module uart_tx_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          i_req,
    input  logic [N_REQ*DATA_W-1:0]   i_data,
    output logic [N_REQ-1:0]          o_ack,
    output logic [N_REQ-1:0]          o_grant,
    output logic                      o_tx_start,
    output logic [DATA_W-1:0]         o_tx_data,
    input  logic                      i_tx_busy,
    output logic                      o_busy
);

    // Pointer is kept at least 2 bits wide so small configurations share one layout.
    localparam int PW = ($clog2(N_REQ) < 2) ? 2 : $clog2(N_REQ);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_START     = 2'd1;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

    logic [1:0]        state;
    logic [PW-1:0]     ptr;

    logic              win_vld;
    logic [PW-1:0]     win_idx;
    logic [PW-1:0]     ptr_nxt;
    logic [N_REQ-1:0]  win_oh;
    logic [DATA_W-1:0] win_dat;

    // Search requests starting at the pointer, wrapping; the first set bit wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        ptr_nxt = ptr;
        for (int i = 0; i < N_REQ; i++) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!win_vld && (k == ((int'(ptr) + i) % N_REQ)) && i_req[k]) begin
                    win_vld = 1'b1;
                    win_idx = PW'(k);
                    ptr_nxt = PW'((k + 1) % N_REQ);
                end
            end
        end
    end

    // Decode the winner into a one-hot vector and pick its byte.
    always_comb begin
        win_oh  = '0;
        win_dat = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (win_vld && (k == int'(win_idx))) begin
                win_oh[k] = 1'b1;
                win_dat   = i_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // Frame sequencing: accept in IDLE, pulse start, then follow the transmitter's busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            o_ack      <= '0;
            o_grant    <= '0;
            o_tx_start <= 1'b0;
            o_tx_data  <= '0;
        end else begin
            o_ack      <= '0;
            o_tx_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (win_vld) begin
                        o_ack     <= win_oh;
                        o_grant   <= win_oh;
                        o_tx_data <= win_dat;
                        ptr       <= ptr_nxt;
                        state     <= ST_START;
                    end
                end
                ST_START: begin
                    o_tx_start <= 1'b1;
                    state      <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    // Busy already high on entry counts; a short glitch is enough to advance.
                    if (i_tx_busy) begin
                        state <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!i_tx_busy) begin
                        o_grant <= '0;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with default parameters (4 requesters, 8-bit bytes).
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: the bench plays the transmitter by driving i_tx_busy directly.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  i_req = 4'b0000;
    logic [31:0] i_data = 32'h0;
    logic [3:0]  o_ack;
    logic [3:0]  o_grant;
    logic        o_tx_start;
    logic [7:0]  o_tx_data;
    logic        i_tx_busy = 1'b0;
    logic        o_busy;

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(.N_REQ(4), .DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_req      (i_req),
        .i_data     (i_data),
        .o_ack      (o_ack),
        .o_grant    (o_grant),
        .o_tx_start (o_tx_start),
        .o_tx_data  (o_tx_data),
        .i_tx_busy  (i_tx_busy),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a request in IDLE and check the accept edge.
    task automatic accept(input string tag, input logic [3:0] req, input logic [3:0] exp_oh,
                          input logic [7:0] exp_dat);
        i_req = req;
        tick();
        check({tag, ".ack"},      32'(o_ack),      32'(exp_oh));
        check({tag, ".grant"},    32'(o_grant),    32'(exp_oh));
        check({tag, ".data"},     32'(o_tx_data),  32'(exp_dat));
        check({tag, ".nostart"},  32'(o_tx_start), 32'(0));
        check({tag, ".busy"},     32'(o_busy),     32'(1));
    endtask

    // START -> WAIT_BUSY edge: start pulse, ack already gone.
    task automatic start_step(input string tag, input logic [7:0] exp_dat);
        tick();
        check({tag, ".start"},   32'(o_tx_start), 32'(1));
        check({tag, ".ack_off"}, 32'(o_ack),      32'(0));
        check({tag, ".hold"},    32'(o_tx_data),  32'(exp_dat));
    endtask

    // Transmitter busy for three cycles, then back to IDLE.
    task automatic finish(input string tag);
        i_tx_busy = 1'b1;
        tick();
        check({tag, ".start_off"}, 32'(o_tx_start), 32'(0));
        tick();
        tick();
        check({tag, ".busy_hold"}, 32'(o_busy), 32'(1));
        i_tx_busy = 1'b0;
        tick();
        check({tag, ".idle"},      32'(o_busy),  32'(0));
        check({tag, ".grant_off"}, 32'(o_grant), 32'(0));
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".ack"},   32'(o_ack),      32'(0));
        check({tag, ".grant"}, 32'(o_grant),    32'(0));
        check({tag, ".start"}, 32'(o_tx_start), 32'(0));
        check({tag, ".busy"},  32'(o_busy),     32'(0));
        check({tag, ".data"},  32'(o_tx_data),  32'(0));
    endtask

    initial begin
        // Reset wins over a pending request.
        rst   = 1'b1;
        i_req = 4'b1111;
        i_data = 32'h4332_2110;
        tick();
        tick();
        check_zero("rst");
        rst   = 1'b0;
        i_req = 4'b0000;
        tick();
        tick();
        check_zero("idle_noreq");

        // Single request from requester 1.
        i_data = 32'h0000_A500;
        accept("single", 4'b0010, 4'b0010, 8'hA5);
        i_req = 4'b0000;
        start_step("single", 8'hA5);
        finish("single");

        // All requesting: order 0,1,2,3,0 from a fresh pointer.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        i_data = 32'h4332_2110;
        accept("all0", 4'b1111, 4'b0001, 8'h10); start_step("all0", 8'h10); finish("all0");
        accept("all1", 4'b1111, 4'b0010, 8'h21); start_step("all1", 8'h21); finish("all1");
        accept("all2", 4'b1111, 4'b0100, 8'h32); start_step("all2", 8'h32); finish("all2");
        accept("all3", 4'b1111, 4'b1000, 8'h43); start_step("all3", 8'h43); finish("all3");
        accept("all4", 4'b1111, 4'b0001, 8'h10); start_step("all4", 8'h10); finish("all4");

        // Wrap: grant 2 moves pointer to 3; then 0101 searches 3,0 and picks 0, then 2.
        accept("wrap_a", 4'b0100, 4'b0100, 8'h32); start_step("wrap_a", 8'h32); finish("wrap_a");
        accept("wrap_b", 4'b0101, 4'b0001, 8'h10); start_step("wrap_b", 8'h10); finish("wrap_b");
        accept("wrap_c", 4'b0101, 4'b0100, 8'h32);
        i_req = 4'b0000;
        start_step("wrap_c", 8'h32);
        finish("wrap_c");

        // Request pulsed while in WAIT_DONE is ignored and leaves no trace.
        accept("wd", 4'b0001, 4'b0001, 8'h10);
        i_req = 4'b0000;
        start_step("wd", 8'h10);
        i_tx_busy = 1'b1;
        tick();
        i_req = 4'b0010;
        tick();
        check("wd.no_ack", 32'(o_ack), 32'(0));
        i_req = 4'b0000;
        tick();
        i_tx_busy = 1'b0;
        tick();
        check("wd.idle", 32'(o_busy), 32'(0));
        tick();
        tick();
        check("wd.stay_idle", 32'(o_busy), 32'(0));
        check("wd.no_ack2",   32'(o_ack),  32'(0));
        check("wd.data_hold", 32'(o_tx_data), 32'(8'h10));

        // One-cycle busy glitch still completes the frame.
        accept("glitch", 4'b1000, 4'b1000, 8'h43);
        i_req = 4'b0000;
        start_step("glitch", 8'h43);
        i_tx_busy = 1'b1;
        tick();
        check("glitch.wait_done", 32'(o_busy), 32'(1));
        i_tx_busy = 1'b0;
        tick();
        check("glitch.idle",  32'(o_busy),  32'(0));
        check("glitch.grant", 32'(o_grant), 32'(0));

        // Reset in WAIT_DONE with transmitter still busy.
        accept("mid", 4'b0010, 4'b0010, 8'h21);
        i_req = 4'b0000;
        start_step("mid", 8'h21);
        i_tx_busy = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_zero("mid_rst");
        rst = 1'b0;
        i_tx_busy = 1'b0;
        accept("post_rst3", 4'b1000, 4'b1000, 8'h43);
        i_req = 4'b0000;
        start_step("post_rst3", 8'h43);
        finish("post_rst3");

        // Pointer restarts at 0 after reset: 1010 picks requester 1.
        accept("pre_rst", 4'b0100, 4'b0100, 8'h32);
        i_req = 4'b0000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        accept("ptr_rst", 4'b1010, 4'b0010, 8'h21);
        i_req = 4'b0000;
        start_step("ptr_rst", 8'h21);
        finish("ptr_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing one UART transmitter (2..8).
REQ-002 SHALL have parameter DATA_W, default 8, byte width per requester.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port i_req  input  N_REQ  per-requester "byte pending" level; bit k = requester k.
REQ-006 SHALL have port i_data  input  N_REQ*DATA_W  packed bytes; requester k at bits [k*DATA_W +: DATA_W].
REQ-007 SHALL have port o_ack  output  N_REQ  one-cycle, one-hot pulse: byte of requester k accepted.
REQ-008 SHALL have port o_grant  output  N_REQ  one-hot owner of the transmitter; all-zero when idle.
REQ-009 SHALL have port o_tx_start  output  1  one-cycle pulse telling the transmitter to begin a frame.
REQ-010 SHALL have port o_tx_data  output  DATA_W  byte to transmit; stable from o_tx_start until the next accept.
REQ-011 SHALL have port i_tx_busy  input  1  high while the transmitter is shifting start/data/stop bits.
REQ-012 SHALL have port o_busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, START, WAIT_BUSY, WAIT_DONE.
REQ-014 IDLE, any i_req bit set: select winner per round-robin (REQ-019), latch its i_data into o_tx_data, pulse o_ack[winner], set o_grant[winner], go to START in the same edge.
REQ-015 IDLE, i_req all zero: remain in IDLE; o_ack, o_grant, o_tx_start all zero.
REQ-016 START: assert o_tx_start for exactly one cycle; go to WAIT_BUSY.
REQ-017 WAIT_BUSY: stay until i_tx_busy=1, then go to WAIT_DONE; i_tx_busy already high on entry counts immediately.
REQ-018 WAIT_DONE: stay until i_tx_busy=0, then clear o_grant and go to IDLE.
REQ-019 Round-robin: 2-bit-or-wider pointer P (reset 0); search i_req from index P upward, wrapping modulo N_REQ; first set bit wins; on each accept, P <= winner+1 mod N_REQ.
REQ-020 Latency: i_req[k] high in IDLE at edge t -> o_ack[k] and o_grant[k] high after edge t -> o_tx_start high after edge t+1.
REQ-021 i_req changes outside IDLE SHALL be ignored; requests are evaluated only in IDLE.
REQ-022 Requester holds i_req and i_data until o_ack; dropping i_req before o_ack withdraws the request with no transfer.
REQ-023 Single requester continuously requesting SHALL be re-granted on every IDLE visit; minimum IDLE dwell is one cycle between frames.
REQ-024 o_tx_data SHALL NOT change between accept and the next accept; o_ack SHALL pulse once per transferred byte.
REQ-025 No requester starves: with all N_REQ requesting continuously, each SHALL be granted exactly once per N_REQ consecutive frames.
REQ-026 i_tx_busy glitch high then low within WAIT_BUSY SHALL still advance per REQ-017/018 (one frame counted).

Reset
REQ-027 rst high at a rising edge SHALL force state IDLE, P=0, o_ack=0, o_grant=0, o_tx_start=0, o_busy=0, o_tx_data=0.
REQ-028 rst mid-frame SHALL abandon the frame without o_ack for any further byte; the in-flight byte is not retried.
REQ-029 rst SHALL take priority over all other transitions in the same cycle.

Verification
REQ-030 Single request: i_req=4'b0010, i_data[15:8]=8'hA5, transmitter model busy 10416*10 cycles -> o_ack=4'b0010 one cycle, o_tx_start one cycle later with o_tx_data=8'hA5, o_busy falls one cycle after i_tx_busy falls.
REQ-031 All request: i_req=4'b1111 held, bytes 8'h10/8'h21/8'h32/8'h43 -> grant order 0,1,2,3,0, o_tx_data sequence 10,21,32,43,10.
REQ-032 Wrap: P=3 after grant to 2, i_req=4'b0101 -> requester 0 granted before 2 (search 3,0).
REQ-033 Withdrawn request: i_req[1] pulsed high then low while arbiter in WAIT_DONE -> no o_ack[1], arbiter returns to IDLE and stays.
REQ-034 Reset mid-frame: rst high during WAIT_DONE with i_tx_busy=1 -> next cycle all outputs zero, state IDLE; i_req=4'b1000 afterwards -> requester 3 granted (search from P=0).
REQ-035 Loopback: transmitter output wired to the existing UART receiver at 10416 clocks/bit, send 8'hDA then 8'h63 from requesters 0 and 2 -> receiver o_wr pulses twice with o_data 8'hDA then 8'h63.
